data_mem_responder: RTL and testbench

Multi-cycle responder for the CPU data-memory port: accepts one load/store request at a time over a valid/ready handshake, performs RV32I byte/half/word access on a byte-addressed little-endian array, and returns read data or an error over a second valid/ready channel. It sits on the far side of the memory stage's load/store interface and replaces the single-cycle data memory when the pipeline is built with a stall-capable memory stage. Latency is parameterised to model slower backing memory.

---
 rtl/data_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle responder for the CPU data-memory port. Accepts one RV32I
//   load/store at a time, performs a byte/half/word access on a byte-addressed
//   little-endian array after LATENCY cycles, and returns data or an error.
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both high. A producer holds its valid and payload stable until that edge;
//   ready may be asserted independently of valid.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request channel (req_ready = state is IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr            byte address (only the low ADDR_WIDTH bits used)
//   req_wdata           store data, low bytes used for B/H
//   rsp_valid/rsp_ready response channel
//   rsp_rdata           extended load data; 0 for stores and errors
//   rsp_err             misaligned access or illegal funct3
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            dbg_state
);

    localparam int MEM_BYTES = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [2:0]              lat_f3;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    // Array contents are deliberately outside reset.
    logic [7:0] mem [0:MEM_BYTES-1];

    // Address bits above the array size alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    // Byte lanes of the access; aligned accesses never cross the array end,
    // so the +1/+2/+3 wrap only matters for requests that error out anyway.
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    assign a1 = lat_addr + ADDR_WIDTH'(1);
    assign a2 = lat_addr + ADDR_WIDTH'(2);
    assign a3 = lat_addr + ADDR_WIDTH'(3);

    logic [7:0] b0, b1, b2, b3;
    assign b0 = mem[lat_addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    logic                  f3_legal;
    logic                  misaligned;
    logic                  acc_err;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        ld_data    = '0;
        case (lat_f3)
            3'b000: begin
                f3_legal = 1'b1;
                ld_data  = {{(DATA_WIDTH-8){b0[7]}}, b0};
            end
            3'b100: begin
                f3_legal = 1'b1;
                ld_data  = {{(DATA_WIDTH-8){1'b0}}, b0};
            end
            3'b001: begin
                f3_legal   = 1'b1;
                misaligned = lat_addr[0];
                ld_data    = {{(DATA_WIDTH-16){b1[7]}}, b1, b0};
            end
            3'b101: begin
                f3_legal   = 1'b1;
                misaligned = lat_addr[0];
                ld_data    = {{(DATA_WIDTH-16){1'b0}}, b1, b0};
            end
            3'b010: begin
                f3_legal   = 1'b1;
                misaligned = (lat_addr[1:0] != 2'b00);
                ld_data    = DATA_WIDTH'({b3, b2, b1, b0});
            end
            default: ;
        endcase
        // Unsigned variants exist for loads only.
        acc_err = !f3_legal || misaligned || (lat_we && lat_f3[2]);
    end

    // The access happens on the final WAIT edge; a reset before it leaves
    // state out of WAIT, so the write is dropped.
    logic access_now;
    logic commit;
    assign access_now = (state == WAIT) && (cnt == 4'd0);
    assign commit     = access_now && lat_we && !acc_err;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[lat_addr] <= lat_wdata[7:0];
            if (lat_f3[1:0] != 2'b00) begin
                mem[a1] <= lat_wdata[15:8];
            end
            if (lat_f3[1:0] == 2'b10) begin
                mem[a2] <= lat_wdata[23:16];
                mem[a3] <= lat_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_addr  <= req_addr[ADDR_WIDTH-1:0];
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_we) ? '0 : ld_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    int vectors    = 0;
    int miscompares = 0;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for rsp_valid; returns the number of rising edges
    // since the acceptance edge. Called at the negedge after acceptance.
    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    // One full transaction with rsp_ready held high.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        rsp_ready  = 1'b1;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(k);
        check({tag, ".latency"}, 32'(k), 32'(LAT));
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, ".idle_after"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.state", 32'(dbg_state), 32'd0);

        // Word store and load
        xact("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store and byte loads
        xact("sb101", 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1'b0);
        xact("lw100b", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADA5EF, 1'b0);
        xact("lb101", 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFA5, 1'b0);
        xact("lbu101", 1'b0, 3'b100, 32'h101, 32'h0, 32'h000000A5, 1'b0);

        // Half store and half loads
        xact("sh102", 1'b1, 3'b001, 32'h102, 32'h00008001, 32'h0, 1'b0);
        xact("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8001, 1'b0);
        xact("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h00008001, 1'b0);
        xact("lw100h", 1'b0, 3'b010, 32'h100, 32'h0, 32'h8001A5EF, 1'b0);

        // Errors and aliasing
        xact("lw102mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1);
        xact("lh101mis", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1);
        xact("sw101mis", 1'b1, 3'b010, 32'h101, 32'h11111111, 32'h0, 1'b1);
        xact("sbu_ill", 1'b1, 3'b100, 32'h100, 32'h22222222, 32'h0, 1'b1);
        xact("lw100e", 1'b0, 3'b010, 32'h100, 32'h0, 32'h8001A5EF, 1'b0);
        xact("f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
        xact("alias", 1'b0, 3'b010, 32'h20100, 32'h0, 32'h8001A5EF, 1'b0);

        // Backpressure: response held while rsp_ready is low, req_valid high
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        rsp_ready  = 1'b0;
        @(negedge clk);
        // Changed payload is ignored outside IDLE; it becomes the next request.
        req_funct3 = 3'b100;
        req_addr   = 32'h101;
        wait_rsp(k);
        check("bp.latency", 32'(k), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", 32'(rsp_valid), 32'd1);
            check("bp.rdata", rsp_rdata, 32'h8001A5EF);
            check("bp.err", 32'(rsp_err), 32'd0);
            check("bp.req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        // Handshake edge passed: idle now, second request not yet taken.
        check("bp.hs_valid", 32'(rsp_valid), 32'd0);
        check("bp.hs_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp.accept2", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_rsp(k);
        check("bp2.latency", 32'(k), 32'(LAT));
        check("bp2.rdata", rsp_rdata, 32'h000000A5);
        @(negedge clk);

        // Reset during WAIT drops the store
        xact("sw200", 1'b1, 3'b010, 32'h200, 32'h12345678, 32'h0, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        req_wdata  = 32'hFFFFFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw.in_wait", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw.state", 32'(dbg_state), 32'd0);
        check("rstw.valid", 32'(rsp_valid), 32'd0);
        check("rstw.req_ready", 32'(req_ready), 32'd1);
        #1;
        rst = 1'b0;
        xact("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0);

        // Reset during RESP discards the response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        rsp_ready  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(k);
        check("rstr.rdata_pre", rsp_rdata, 32'h12345678);
        rst = 1'b1;
        #1;
        check("rstr.valid", 32'(rsp_valid), 32'd0);
        check("rstr.rdata", rsp_rdata, 32'h0);
        check("rstr.err", 32'(rsp_err), 32'd0);
        #1;
        rst = 1'b0;
        xact("lw200b", 1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
